// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the load/store sequencer.
// Size codes, FSM states and the alignment rule.
package mem_access_unit_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    RDW  = 3'd2,
    WR   = 3'd3,
    FIN  = 3'd4
  } state_e;

  function automatic logic misaligned(
    input size_e      sz,
    input logic [1:0] a
  );
    logic bad;
    bad = 1'b1;
    case (sz)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = a[0];
      SZ_WORD: bad = |a;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_access_unit_lane.sv
// Lane extraction/extension for loads and lane merge for stores.
// Purely combinational; little-endian byte lanes.
module mem_lane_align
  import mem_access_unit_pkg::*;
(
  input  logic [31:0] mem_q,
  input  logic [1:0]  addr_q,
  input  size_e       size_q,
  input  logic        sign_ext_q,
  input  logic [31:0] wdata_q,
  output logic [31:0] load_val,
  output logic [31:0] merge_val
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte    = mem_q[{addr_q, 3'b000} +: 8];
    w_half    = addr_q[1] ? mem_q[31:16] : mem_q[15:0];
    load_val  = mem_q;
    merge_val = mem_q;
    unique case (size_q)
      SZ_BYTE: begin
        load_val = {{24{sign_ext_q & w_byte[7]}}, w_byte};
        merge_val[{addr_q, 3'b000} +: 8] = wdata_q[7:0];
      end
      SZ_HALF: begin
        load_val = {{16{sign_ext_q & w_half[15]}}, w_half};
        merge_val[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      end
      SZ_WORD: merge_val = wdata_q;
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store sequencer feeding the memory data register.
// Runs read, write or read-modify-write cycles on a sync RAM.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we_op,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [31:0]       rdata,
  output logic [ADDR_W-1:0] mem_a,
  output logic [31:0]       mem_d,
  output logic              mem_we,
  input  logic [31:0]       mem_q
);

  state_e            r_state;
  state_e            w_next;
  logic              r_we;
  size_e             r_size;
  logic              r_sext;
  logic [ADDR_W+1:0] r_addr;
  logic [31:0]       r_wdata;
  logic              r_err;
  logic [31:0]       r_merge;
  logic [31:0]       r_rdata;
  logic              w_bad;
  logic              w_accept;
  logic [31:0]       w_load;
  logic [31:0]       w_merge;
  logic              w_unused_hi;

  assign w_unused_hi = ^addr[31:ADDR_W+2];
  assign w_bad       = misaligned(size_e'(size), addr[1:0]);
  assign w_accept    = (r_state == IDLE) && req;

  mem_lane_align u_lane (
    .mem_q      (mem_q),
    .addr_q     (r_addr[1:0]),
    .size_q     (r_size),
    .sign_ext_q (r_sext),
    .wdata_q    (r_wdata),
    .load_val   (w_load),
    .merge_val  (w_merge)
  );

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (req) begin
          if (w_bad)
            w_next = FIN;
          else if (we_op && size_e'(size) == SZ_WORD)
            w_next = WR;
          else
            w_next = RD;
        end
      end
      RD:  w_next = RDW;
      RDW: w_next = r_we ? WR : FIN;
      WR:  w_next = FIN;
      FIN: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_we    <= 1'b0;
      r_size  <= SZ_BYTE;
      r_sext  <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_err   <= 1'b0;
      r_merge <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_we    <= we_op;
        r_size  <= size_e'(size);
        r_sext  <= sign_ext;
        r_addr  <= addr[ADDR_W+1:0];
        r_wdata <= wdata;
        r_err   <= w_bad;
      end
      if (r_state == RDW) begin
        if (r_we)
          r_merge <= w_merge;
        else
          r_rdata <= w_load;
      end
    end
  end

  // Memory strobes come from state alone so reset kills them at once.
  assign busy   = (r_state != IDLE);
  assign done   = (r_state == FIN);
  assign err    = (r_state == FIN) && r_err;
  assign rdata  = r_rdata;
  assign mem_a  = r_addr[ADDR_W+1:2];
  assign mem_we = (r_state == WR);
  assign mem_d  = (r_state != WR) ? 32'h0 :
                  (r_size == SZ_WORD) ? r_wdata : r_merge;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a scoreboard queue.
// Sync RAM model sits on the memory port.
module tb_mem_access_unit;

  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req = 1'b0;
  logic          we_op = 1'b0;
  logic [1:0]    size = 2'b00;
  logic          sign_ext = 1'b0;
  logic [31:0]   addr = '0;
  logic [31:0]   wdata = '0;
  logic          busy, done, err, mem_we;
  logic [31:0]   rdata, mem_d;
  logic [AW-1:0] mem_a;
  logic [31:0]   mem_q;

  logic          pre_we = 1'b0;
  logic [AW-1:0] pre_a = '0;
  logic [31:0]   pre_d = '0;
  logic [31:0]   mem [0:(1<<AW)-1];

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_rd;

  typedef struct {
    string       tag;
    logic        err;
    logic [31:0] rd;
    int          lat;
    int          nwe;
    logic [7:0]  wa;
    logic [31:0] wd;
  } exp_t;

  exp_t sbq[$];

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_W(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .we_op    (we_op),
    .size     (size),
    .sign_ext (sign_ext),
    .addr     (addr),
    .wdata    (wdata),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .rdata    (rdata),
    .mem_a    (mem_a),
    .mem_d    (mem_d),
    .mem_we   (mem_we),
    .mem_q    (mem_q)
  );

  always @(posedge clk) begin
    if (pre_we)
      mem[pre_a] <= pre_d;
    else if (mem_we)
      mem[mem_a] <= mem_d;
    mem_q <= mem[mem_a];
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [31:0] d);
    @(negedge clk);
    pre_we = 1'b1;
    pre_a  = a;
    pre_d  = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic access(input string tag, input logic w,
                        input logic [1:0] sz, input logic sx,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic e, input int lat, input int nwe,
                        input logic [31:0] wexp, input logic hold);
    exp_t x;
    exp_t y;
    int nw;
    int got_lat;
    logic seen;
    logic got_err;
    logic [7:0] ga;
    logic [31:0] gd;
    x.tag = tag;
    x.err = e;
    x.rd  = exp_rd;
    x.lat = lat;
    x.nwe = nwe;
    x.wa  = a[9:2];
    x.wd  = wexp;
    sbq.push_back(x);
    @(negedge clk);
    req      = 1'b1;
    we_op    = w;
    size     = sz;
    sign_ext = sx;
    addr     = a;
    wdata    = wd;
    @(posedge clk);
    #1;
    if (!hold) req = 1'b0;
    nw = 0;
    got_lat = 0;
    seen = 1'b0;
    got_err = 1'b0;
    ga = '0;
    gd = '0;
    for (int i = 1; i <= 10; i++) begin
      if (mem_we) begin
        nw++;
        ga = mem_a;
        gd = mem_d;
      end
      if (done) begin
        seen = 1'b1;
        got_lat = i;
        got_err = err;
        break;
      end
      @(posedge clk);
      #1;
    end
    req = 1'b0;
    y = sbq.pop_front();
    check({y.tag, " done_seen"}, 32'(seen), 32'd1);
    check({y.tag, " latency"}, 32'(got_lat), 32'(y.lat));
    check({y.tag, " err"}, 32'(got_err), 32'(y.err));
    check({y.tag, " rdata"}, rdata, y.rd);
    check({y.tag, " we_cycles"}, 32'(nw), 32'(y.nwe));
    if (y.nwe > 0) begin
      check({y.tag, " mem_a"}, 32'(ga), 32'(y.wa));
      check({y.tag, " mem_d"}, gd, y.wd);
    end
    @(posedge clk);
    #1;
    check({y.tag, " idle_after"}, 32'(busy), 32'd0);
    if (hold) begin
      @(posedge clk);
      #1;
      check({y.tag, " no_restart"}, 32'(busy), 32'd0);
    end
  endtask

  initial begin
    exp_rd = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst err", 32'(err), 32'd0);
    check("rst mem_we", 32'(mem_we), 32'd0);
    check("rst rdata", rdata, 32'h0);
    check("rst mem_d", mem_d, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    preload(8'd4, 32'h8899AABB);
    exp_rd = 32'hFFFFFFAA;
    access("lb_sx", 1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 1'b0, 3, 0, 32'h0, 1'b0);
    exp_rd = 32'h000000AA;
    access("lb_zx", 1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 1'b0, 3, 0, 32'h0, 1'b0);
    exp_rd = 32'h00008899;
    access("lh_zx", 1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 1'b0, 3, 0, 32'h0, 1'b0);
    exp_rd = 32'hFFFF8899;
    access("lh_sx", 1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 1'b0, 3, 0, 32'h0, 1'b0);
    exp_rd = 32'h8899AABB;
    access("lw", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, 3, 0, 32'h0, 1'b0);

    access("sb", 1'b1, 2'b00, 1'b0, 32'h13, 32'h12345677, 1'b0, 4, 1,
           32'h7799AABB, 1'b0);
    check("sb mem4", mem[4], 32'h7799AABB);
    preload(8'd4, 32'h8899AABB);

    access("sw", 1'b1, 2'b10, 1'b0, 32'h14, 32'hDEADBEEF, 1'b0, 2, 1,
           32'hDEADBEEF, 1'b0);
    exp_rd = 32'hDEADBEEF;
    access("lw_back", 1'b0, 2'b10, 1'b0, 32'h14, 32'h0, 1'b0, 3, 0, 32'h0, 1'b0);

    access("mis_lw", 1'b0, 2'b10, 1'b0, 32'h12, 32'h0, 1'b1, 1, 0, 32'h0, 1'b0);
    access("mis_sh", 1'b1, 2'b01, 1'b0, 32'h11, 32'hFFFF, 1'b1, 1, 0, 32'h0, 1'b0);
    access("ill_sz", 1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 1'b1, 1, 0, 32'h0, 1'b0);

    access("sh_hold", 1'b1, 2'b01, 1'b0, 32'h16, 32'h1234CAFE, 1'b0, 4, 1,
           32'hCAFEBEEF, 1'b1);
    check("sh mem5", mem[5], 32'hCAFEBEEF);

    @(negedge clk);
    req   = 1'b1;
    we_op = 1'b1;
    size  = 2'b01;
    addr  = 32'h10;
    wdata = 32'h00001111;
    @(posedge clk);
    #1;
    req = 1'b0;
    @(posedge clk);
    #1;
    check("mid busy_rdw", 32'(busy), 32'd1);
    rst = 1'b0;
    #1;
    check("mid busy", 32'(busy), 32'd0);
    check("mid done", 32'(done), 32'd0);
    check("mid mem_we", 32'(mem_we), 32'd0);
    check("mid rdata", rdata, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("mid no_done", 32'(done | mem_we), 32'd0);
    end
    check("mid mem4", mem[4], 32'h8899AABB);
    @(negedge clk);
    rst = 1'b1;
    exp_rd = 32'h8899AABB;
    access("lw_after", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, 3, 0, 32'h0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Load/store sequencer between the multi-cycle CPU control path and the word-wide synchronous data memory, directly upstream of the memory data register. It accepts one access request from the control unit and performs the memory cycles: read, read-modify-write for sub-word stores, or write. It returns aligned, sign- or zero-extended load data on rdata, which the memory data register samples. It handles byte, halfword and word accesses and flags misaligned requests.

Parameters:
ADDR_W, 8, word-address width of data memory (memory depth 2**ADDR_W words)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, asynchronous, active-low (0 = reset)
req  input  1  access request from control unit; sampled only in IDLE
we_op  input  1  1 = store, 0 = load
size  input  2  00 byte, 01 halfword, 10 word, 11 illegal
sign_ext  input  1  loads only: 1 sign-extend, 0 zero-extend
addr  input  32  byte address
wdata  input  32  store data; the low byte/half is used for sub-word stores
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle completion pulse
err  output  1  high with done when the request was misaligned or illegal
rdata  output  32  last completed load result, to memory data register
mem_a  output  ADDR_W  word address to memory = addr_q[ADDR_W+1:2]
mem_d  output  32  write data to memory
mem_we  output  1  memory write enable
mem_q  input  32  memory read data, valid one cycle after mem_a is presented

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - busy=0, done=0, err=0, mem_we=0, rdata=0, all internal capture registers 0.
  - mem_we is decoded from state only, so it drops immediately when reset asserts.
- IDLE, req=1 at a clock edge: capture we_op, size, sign_ext, addr, wdata into *_q registers. req is ignored in every other state. Next state from IDLE:
  - Misaligned/illegal (size=11; size=01 with addr[0]=1; size=10 with addr[1:0]!=0): FIN with err flag set. No memory activity.
  - Load: RD.
  - Word store: WR.
  - Sub-word store: RD.
- RD: mem_a driven from addr_q; next state RDW.
- RDW (mem_q valid):
  - Load: rdata <= extracted value; next state FIN.
  - Sub-word store: merge register <= mem_q with the selected lane replaced; next state WR.
- WR: mem_we=1 for exactly this cycle.
  - Word store: mem_d = wdata_q.
  - Sub-word store: mem_d = merge register.
  - Next state FIN.
- FIN: done=1, err=err flag; next state IDLE. busy=1 in FIN.
- Latency, counted in cycles after the accepting edge, to the cycle in which done is high:
  - Misaligned/illegal: 1
  - Word store: 2
  - Load: 3
  - Sub-word store: 4
- Back-to-back: a new req can be accepted on the edge that leaves FIN into IDLE plus one, i.e. in the first IDLE cycle. The minimum spacing is therefore the latency plus one.
- Lane rules (little-endian):
  - Byte lane k = addr_q[1:0] occupies bits [8k+7:8k].
  - Half lane = addr_q[1]: 0 selects [15:0], 1 selects [31:16].
  - Extension fills from bit 7 (byte) or bit 15 (half) when sign_ext_q=1; otherwise zero-fills.
  - Word loads pass through unchanged.
  - Stores write wdata_q[7:0] or wdata_q[15:0] into the lane; all other lanes are preserved.
- rdata changes only at RDW of a load. Stores, errors and reset-free idle leave it holding its value.
- mem_d = 0 and mem_we = 0 outside WR. mem_a holds addr_q in all states.
- Reset mid-operation: the access is abandoned and done is never issued.
  - If reset asserts before the WR edge, memory is not written.
  - A partially merged word is discarded.

Decomposition:
- Shared package: size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and FSM state encodings (IDLE, RD, RDW, WR, FIN, 3 bits).
- One combinational sub-module, mem_lane_align:
  - Inputs: mem_q, addr_q[1:0], size_q, sign_ext_q, wdata_q.
  - Outputs: load_val (extracted and extended) and merge_val (lane-replaced word).
- The FSM and registers stay in mem_access_unit.

Test Plan:
- Preload mem[4]=0x8899AABB. Load byte, addr 0x11, sign_ext=1 -> rdata=0xFFFFFFAA, done 3 cycles after accept, mem_we never high. Same access with sign_ext=0 -> rdata=0x000000AA.
- Preload mem[4]=0x8899AABB. Load half, addr 0x12, sign_ext=0 -> rdata=0x00008899; with sign_ext=1 -> rdata=0xFFFF8899. Load word at 0x10 -> rdata=0x8899AABB.
- Preload mem[4]=0x8899AABB. Store byte, addr 0x13, wdata 0x12345677 -> exactly one mem_we cycle with mem_a=4, mem_d=0x7799AABB; done 4 cycles after accept; rdata unchanged.
- Store word, addr 0x14, wdata 0xDEADBEEF -> mem_we in cycle 1 with mem_a=5; done in cycle 2; a subsequent load word from 0x14 returns 0xDEADBEEF.
- Load word at 0x12, store half at 0x11, and size=11 -> done=1 and err=1 one cycle after accept, mem_we stays 0, rdata unchanged. req held high while busy -> no second access starts.
- Store half at 0x10 with mem[4]=0x8899AABB; drive rst=0 during RDW -> busy, done and mem_we go 0 immediately, rdata=0, mem[4] still 0x8899AABB. After release, a fresh load word at 0x10 completes normally.
